// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Front-end controller for the MP3 decode path. Hunts for MPEG-1 Layer III
// frame sync in the incoming byte stream, decodes the 4-byte header, drops the
// optional CRC, forwards the side-info bytes to the side-info parser and the
// remaining main-data bytes to the reservoir, then expects the next frame
// header at the computed frame boundary.
//
// Ports:
//   clk          in   single clock
//   rst_n        in   asynchronous reset, active low
//   axiid[7:0]   in   input byte
//   axiiv        in   input byte valid (no backpressure)
//   side_axiod   out  side-info byte (registered, 1 cycle after input)
//   side_axiov   out  side-info byte valid
//   main_axiod   out  main-data byte (registered, 1 cycle after input)
//   main_axiov   out  main-data byte valid
//   frame_start  out  one-cycle pulse when a header is accepted
//   mono         out  channel mode == 2'b11 for the current frame
//   mode         out  header mode bits
//   sr_idx       out  header sampling-rate index
//   frame_len    out  total frame bytes, header included
//   sync_err     out  one-cycle pulse on header reject / resync failure
//   frame_count  out  accepted frames, wraps modulo 2^FRAME_CNT_W
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int STRICT_RESYNC = 1,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             axiid,
    input  logic                   axiiv,
    output logic [7:0]             side_axiod,
    output logic                   side_axiov,
    output logic [7:0]             main_axiod,
    output logic                   main_axiov,
    output logic                   frame_start,
    output logic                   mono,
    output logic [1:0]             mode,
    output logic [1:0]             sr_idx,
    output logic [10:0]            frame_len,
    output logic                   sync_err,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_SYNC2,
        S_HDR2,
        S_HDR3,
        S_CRC,
        S_SIDE,
        S_MAIN,
        S_EXPECT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_prot;
    logic [3:0]  r_br_idx;
    logic [1:0]  r_sr_pend;
    logic        r_pad;
    logic [10:0] r_cnt;
    logic [10:0] r_main_len;

    logic        w_is_ff;
    logic        w_hdr2_bad;
    logic        w_err;
    logic        w_accept;
    logic        w_side_fwd;
    logic        w_main_fwd;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_latch_prot;
    logic        w_latch_hdr2;
    logic        w_hdr_mono;
    logic [10:0] w_frame_len;
    logic [10:0] w_main_len;
    logic [10:0] w_side_last;

    // floor(144 * bitrate / samplerate) for each valid bitrate index and
    // sample-rate index (0: 44.1 kHz, 1: 48 kHz, 2: 32 kHz).
    function automatic logic [10:0] f_base_len(input logic [3:0] br, input logic [1:0] sr);
        logic [10:0] l44;
        logic [10:0] l48;
        logic [10:0] l32;
        case (br)
            4'd1:    begin l44 = 11'd104;  l48 = 11'd96;  l32 = 11'd144;  end
            4'd2:    begin l44 = 11'd130;  l48 = 11'd120; l32 = 11'd180;  end
            4'd3:    begin l44 = 11'd156;  l48 = 11'd144; l32 = 11'd216;  end
            4'd4:    begin l44 = 11'd182;  l48 = 11'd168; l32 = 11'd252;  end
            4'd5:    begin l44 = 11'd208;  l48 = 11'd192; l32 = 11'd288;  end
            4'd6:    begin l44 = 11'd261;  l48 = 11'd240; l32 = 11'd360;  end
            4'd7:    begin l44 = 11'd313;  l48 = 11'd288; l32 = 11'd432;  end
            4'd8:    begin l44 = 11'd365;  l48 = 11'd336; l32 = 11'd504;  end
            4'd9:    begin l44 = 11'd417;  l48 = 11'd384; l32 = 11'd576;  end
            4'd10:   begin l44 = 11'd522;  l48 = 11'd480; l32 = 11'd720;  end
            4'd11:   begin l44 = 11'd626;  l48 = 11'd576; l32 = 11'd864;  end
            4'd12:   begin l44 = 11'd731;  l48 = 11'd672; l32 = 11'd1008; end
            4'd13:   begin l44 = 11'd835;  l48 = 11'd768; l32 = 11'd1152; end
            4'd14:   begin l44 = 11'd1044; l48 = 11'd960; l32 = 11'd1440; end
            default: begin l44 = 11'd0;    l48 = 11'd0;   l32 = 11'd0;    end
        endcase
        case (sr)
            2'd0:    f_base_len = l44;
            2'd1:    f_base_len = l48;
            default: f_base_len = l32;
        endcase
    endfunction

    assign w_is_ff     = (axiid == 8'hFF);
    assign w_hdr2_bad  = (axiid[7:4] == 4'd0) || (axiid[7:4] == 4'd15) || (axiid[3:2] == 2'd3);
    assign w_hdr_mono  = (axiid[7:6] == 2'b11);
    assign w_frame_len = f_base_len(r_br_idx, r_sr_pend) + {10'd0, r_pad};
    // Bytes left after header, optional CRC and side info.
    assign w_main_len  = w_frame_len - 11'd4 - (r_prot ? 11'd0 : 11'd2)
                         - (w_hdr_mono ? 11'd17 : 11'd32);
    assign w_side_last = mono ? 11'd16 : 11'd31;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_err        = 1'b0;
        w_accept     = 1'b0;
        w_side_fwd   = 1'b0;
        w_main_fwd   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_latch_prot = 1'b0;
        w_latch_hdr2 = 1'b0;
        if (axiiv) begin
            case (r_state)
                S_HUNT: begin
                    if (w_is_ff) w_state_nxt = S_SYNC2;
                end
                S_SYNC2: begin
                    if (axiid[7:1] == 7'b1111101) begin
                        w_latch_prot = 1'b1;
                        w_state_nxt  = S_HDR2;
                    end else if (!w_is_ff) begin
                        w_state_nxt = S_HUNT;
                    end
                end
                S_HDR2: begin
                    if (w_hdr2_bad) begin
                        w_err       = 1'b1;
                        // A rejected 0xFF may itself be the start of a real sync.
                        w_state_nxt = w_is_ff ? S_SYNC2 : S_HUNT;
                    end else begin
                        w_latch_hdr2 = 1'b1;
                        w_state_nxt  = S_HDR3;
                    end
                end
                S_HDR3: begin
                    w_accept    = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_prot ? S_SIDE : S_CRC;
                end
                S_CRC: begin
                    if (r_cnt == 11'd1) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_SIDE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_SIDE: begin
                    w_side_fwd = 1'b1;
                    if (r_cnt == w_side_last) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_MAIN;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_MAIN: begin
                    w_main_fwd = 1'b1;
                    if (r_cnt == r_main_len - 11'd1) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_EXPECT;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_EXPECT: begin
                    if (w_is_ff) begin
                        w_state_nxt = S_SYNC2;
                    end else begin
                        w_state_nxt = S_HUNT;
                        w_err       = (STRICT_RESYNC != 0);
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prot      <= 1'b0;
            r_br_idx    <= 4'd0;
            r_sr_pend   <= 2'd0;
            r_pad       <= 1'b0;
            r_cnt       <= 11'd0;
            r_main_len  <= 11'd0;
            side_axiod  <= 8'd0;
            side_axiov  <= 1'b0;
            main_axiod  <= 8'd0;
            main_axiov  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            mono        <= 1'b0;
            mode        <= 2'd0;
            sr_idx      <= 2'd0;
            frame_len   <= 11'd0;
            frame_count <= '0;
        end else begin
            side_axiov  <= w_side_fwd;
            main_axiov  <= w_main_fwd;
            frame_start <= w_accept;
            sync_err    <= w_err;
            if (w_side_fwd) side_axiod <= axiid;
            if (w_main_fwd) main_axiod <= axiid;

            if (w_cnt_clr) begin
                r_cnt <= 11'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 11'd1;
            end

            if (w_latch_prot) r_prot <= axiid[0];
            if (w_latch_hdr2) begin
                r_br_idx  <= axiid[7:4];
                r_sr_pend <= axiid[3:2];
                r_pad     <= axiid[1];
            end

            // Visible header fields only change when a whole header is accepted.
            if (w_accept) begin
                mode        <= axiid[7:6];
                mono        <= w_hdr_mono;
                sr_idx      <= r_sr_pend;
                frame_len   <= w_frame_len;
                r_main_len  <= w_main_len;
                frame_count <= frame_count + FRAME_CNT_W'(1);
            end
        end
    end

endmodule
